// File: rtl/nested_object_buffer.sv
// Entry buffer between the field-table fetch stage and the field serializers.
// Ring buffer of decoded field-table entries with first-word fall-through
// output, plus a bounded stack of object base addresses that follows nested
// sub-messages as entries are consumed.
module nested_object_buffer #(
  parameter int unsigned       DEPTH       = 64,
  parameter int unsigned       STACK_DEPTH = 16,
  parameter int unsigned       ADDR_W      = 64,
  parameter int unsigned       FID_W       = 8,
  parameter int unsigned       PAYLOAD_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_BASE  = 'h100
) (
  input  logic                           clk,
  input  logic                           reset,
  // producer side
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [FID_W-1:0]               in_field_id,
  input  logic                           in_nested,
  input  logic [ADDR_W-1:0]              in_offset,
  input  logic [PAYLOAD_W-1:0]           in_payload,
  // serializer side
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [FID_W-1:0]               out_field_id,
  output logic                           out_nested,
  output logic [ADDR_W-1:0]              out_offset,
  output logic [PAYLOAD_W-1:0]           out_payload,
  // control
  input  logic [ADDR_W-1:0]              root_addr,
  input  logic                           root_addr_valid,
  input  logic                           flush,
  input  logic                           err_clear,
  // status
  output logic [ADDR_W-1:0]              base_addr,
  output logic [$clog2(STACK_DEPTH)-1:0] nest_level,
  output logic [$clog2(DEPTH):0]         occupancy,
  output logic                           err_overflow,
  output logic                           err_underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(STACK_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);
  localparam logic [SW-1:0] SpMax     = SW'(STACK_DEPTH - 1);

  // Entry storage (not reset; contents are don't-care until written)
  logic [FID_W-1:0]     fid_mem    [DEPTH];
  logic                 nested_mem [DEPTH];
  logic [ADDR_W-1:0]    off_mem    [DEPTH];
  logic [PAYLOAD_W-1:0] pay_mem    [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [SW-1:0]     sp_q, sp_d;

  logic err_ovf_q, err_ovf_d;
  logic err_udf_q, err_udf_d;

  logic                 push, pop;
  logic                 stack_act, head_end, head_nest, stack_wr;
  logic                 ovf_event, udf_event;
  logic [FID_W-1:0]     head_fid;
  logic                 head_nested;
  logic [ADDR_W-1:0]    head_off;
  logic [PAYLOAD_W-1:0] head_pay;

  assign in_ready  = (count_q != CountFull);
  assign out_valid = (count_q != '0);

  // Flush discards any concurrent transfer on either side
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  assign head_fid    = fid_mem[rd_ptr_q];
  assign head_nested = nested_mem[rd_ptr_q];
  assign head_off    = off_mem[rd_ptr_q];
  assign head_pay    = pay_mem[rd_ptr_q];

  // Head entry is masked to zero while empty so stale slots never leak out
  always_comb begin
    out_field_id = '0;
    out_nested   = 1'b0;
    out_offset   = '0;
    out_payload  = '0;
    if (out_valid) begin
      out_field_id = head_fid;
      out_nested   = head_nested;
      out_offset   = head_off;
      out_payload  = head_pay;
    end
  end

  // A root load overrides whatever the popped entry would do to the stack
  assign stack_act = pop & ~root_addr_valid;
  assign head_end  = (head_fid == '0);
  assign head_nest = head_nested & ~head_end;
  assign stack_wr  = stack_act & head_nest & (sp_q != SpMax);
  assign ovf_event = stack_act & head_nest & (sp_q == SpMax);
  assign udf_event = stack_act & head_end & (sp_q == '0);

  // Next-state for pointers, count, stack pointer and sticky error flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sp_d     = sp_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      sp_d     = '0;
    end else if (root_addr_valid) begin
      sp_d = '0;
    end else if (stack_act) begin
      if (head_end && sp_q != '0)             sp_d = sp_q - 1'b1;
      else if (head_nest && sp_q != SpMax)    sp_d = sp_q + 1'b1;
    end

    // A same-cycle error event beats err_clear
    err_ovf_d = (err_ovf_q & ~err_clear) | ovf_event;
    err_udf_d = (err_udf_q & ~err_clear) | udf_event;
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sp_q      <= '0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      sp_q      <= sp_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  // Entry slot write on accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      fid_mem[wr_ptr_q]    <= in_field_id;
      nested_mem[wr_ptr_q] <= in_nested;
      off_mem[wr_ptr_q]    <= in_offset;
      pay_mem[wr_ptr_q]    <= in_payload;
    end
  end

  // Address stack: level 0 holds the root base, deeper levels are derived
  always_ff @(posedge clk) begin
    if (reset) begin
      stack_q[0] <= RESET_BASE;
    end else if (root_addr_valid) begin
      stack_q[0] <= root_addr;
    end else if (stack_wr) begin
      stack_q[sp_q + 1'b1] <= stack_q[sp_q] + head_off;
    end
  end

  assign base_addr     = stack_q[sp_q];
  assign nest_level    = sp_q;
  assign occupancy     = count_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_udf_q;

endmodule

// File: tb/tb_nested_object_buffer.sv
// Directed self-checking bench for nested_object_buffer (default parameters).
module tb_nested_object_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [7:0]  in_field_id;
  logic        in_nested;
  logic [63:0] in_offset, in_payload;
  logic        out_valid, out_ready;
  logic [7:0]  out_field_id;
  logic        out_nested;
  logic [63:0] out_offset, out_payload;
  logic [63:0] root_addr;
  logic        root_addr_valid, flush, err_clear;
  logic [63:0] base_addr;
  logic [3:0]  nest_level;
  logic [6:0]  occupancy;
  logic        err_overflow, err_underflow;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  nested_object_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_field_id    (in_field_id),
    .in_nested      (in_nested),
    .in_offset      (in_offset),
    .in_payload     (in_payload),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_field_id   (out_field_id),
    .out_nested     (out_nested),
    .out_offset     (out_offset),
    .out_payload    (out_payload),
    .root_addr      (root_addr),
    .root_addr_valid(root_addr_valid),
    .flush          (flush),
    .err_clear      (err_clear),
    .base_addr      (base_addr),
    .nest_level     (nest_level),
    .occupancy      (occupancy),
    .err_overflow   (err_overflow),
    .err_underflow  (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] fid, input logic nst, input logic [63:0] off);
    in_valid    = 1'b1;
    in_field_id = fid;
    in_nested   = nst;
    in_offset   = off;
    in_payload  = {56'h0, fid} * 64'd3;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic push_seq(input int first, input int n);
    for (int i = 0; i < n; i++) push(8'(first + i), 1'b0, 64'h0);
  endtask

  task automatic drain_seq(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      check("drain_valid", 64'(out_valid), 64'h1);
      check("drain_fid", 64'(out_field_id), 64'(first + i));
      check("drain_payload", out_payload, 64'(first + i) * 64'd3);
      pop1();
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_field_id = '0; in_nested = 1'b0; in_offset = '0; in_payload = '0;
    out_ready = 1'b0; root_addr = '0; root_addr_valid = 1'b0; flush = 1'b0; err_clear = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // Idle after reset
    check("rst_base", base_addr, 64'h100);
    check("rst_occ", 64'(occupancy), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_level", 64'(nest_level), 64'h0);
    check("rst_ovf", 64'(err_overflow), 64'h0);
    check("rst_udf", 64'(err_underflow), 64'h0);
    check("rst_out_fid", 64'(out_field_id), 64'h0);
    check("rst_out_off", out_offset, 64'h0);

    // Fill to capacity, then a held-off 65th offer
    push_seq(1, 64);
    check("full_in_ready", 64'(in_ready), 64'h0);
    check("full_occ", 64'(occupancy), 64'd64);
    push(8'd65, 1'b0, 64'h0);
    check("held_occ", 64'(occupancy), 64'd64);
    check("held_in_ready", 64'(in_ready), 64'h0);
    drain_seq(1, 64);
    check("drained_valid", 64'(out_valid), 64'h0);
    check("drained_occ", 64'(occupancy), 64'h0);

    // Shift pointers off zero, then a second full fill that wraps the ring
    push_seq(101, 20);
    drain_seq(101, 20);
    push_seq(150, 64);
    check("wrap_occ", 64'(occupancy), 64'd64);
    drain_seq(150, 64);
    check("wrap_level", 64'(nest_level), 64'h0);

    // Nesting walk with underflow at the end
    root_addr = 64'h1000;
    root_addr_valid = 1'b1;
    step();
    root_addr_valid = 1'b0;
    check("root_base", base_addr, 64'h1000);
    push(8'd1, 1'b1, 64'h20);
    push(8'd2, 1'b1, 64'h8);
    push(8'd0, 1'b0, 64'h0);
    push(8'd0, 1'b0, 64'h0);
    push(8'd0, 1'b0, 64'h0);
    pop1();
    check("nest1_base", base_addr, 64'h1020);
    check("nest1_level", 64'(nest_level), 64'd1);
    pop1();
    check("nest2_base", base_addr, 64'h1028);
    check("nest2_level", 64'(nest_level), 64'd2);
    pop1();
    check("end1_base", base_addr, 64'h1020);
    check("end1_level", 64'(nest_level), 64'd1);
    pop1();
    check("end2_base", base_addr, 64'h1000);
    check("end2_level", 64'(nest_level), 64'd0);
    check("end2_udf", 64'(err_underflow), 64'h0);
    pop1();
    check("udf_flag", 64'(err_underflow), 64'h1);
    check("udf_base", base_addr, 64'h1000);
    check("udf_level", 64'(nest_level), 64'd0);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("udf_clear", 64'(err_underflow), 64'h0);

    // Stack fills to the top level, then overflows
    for (int i = 0; i < 16; i++) push(8'(i + 1), 1'b1, 64'h1);
    for (int i = 0; i < 15; i++) pop1();
    check("top_level", 64'(nest_level), 64'd15);
    check("top_base", base_addr, 64'h100F);
    check("top_ovf", 64'(err_overflow), 64'h0);
    pop1();
    check("ovf_flag", 64'(err_overflow), 64'h1);
    check("ovf_level", 64'(nest_level), 64'd15);
    check("ovf_base", base_addr, 64'h100F);
    check("ovf_occ", 64'(occupancy), 64'h0);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("ovf_clear", 64'(err_overflow), 64'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush1_level", 64'(nest_level), 64'd0);
    check("flush1_base", base_addr, 64'h1000);

    // Streaming push+pop at constant occupancy, then flush mid-stream
    push_seq(1, 10);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_field_id = 8'(11 + i);
      in_nested = 1'b0;
      in_offset = '0;
      in_payload = 64'(11 + i) * 64'd3;
      out_ready = 1'b1;
      check("stream_occ", 64'(occupancy), 64'd10);
      check("stream_fid", 64'(out_field_id), 64'(1 + i));
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("stream_end_occ", 64'(occupancy), 64'd10);
    check("stream_end_fid", 64'(out_field_id), 64'd21);
    in_valid = 1'b1;
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    check("flush_occ", 64'(occupancy), 64'h0);
    check("flush_valid", 64'(out_valid), 64'h0);
    check("flush_level", 64'(nest_level), 64'h0);
    check("flush_base", base_addr, 64'h1000);
    check("flush_in_ready", 64'(in_ready), 64'h1);

    // Root load races a nested pop: root wins, entry still consumed
    push(8'd5, 1'b1, 64'h40);
    push(8'd6, 1'b0, 64'h0);
    root_addr = 64'h2000;
    root_addr_valid = 1'b1;
    out_ready = 1'b1;
    step();
    root_addr_valid = 1'b0;
    out_ready = 1'b0;
    check("race_base", base_addr, 64'h2000);
    check("race_level", 64'(nest_level), 64'h0);
    check("race_occ", 64'(occupancy), 64'd1);
    check("race_head", 64'(out_field_id), 64'd6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/nested_object_buffer.md
# nested_object_buffer

Parametrised entry buffer between the field-table fetch stage and the field serializers. Holds decoded field-table entries in arrival order and presents them to the serializers through a ready/valid handshake. Tracks the C++ object base address across nested sub-messages with a bounded address stack, and flags stack overflow and underflow. Supersedes the fixed 64-row buffer with configurable depth and widths, explicit backpressure on both sides, flush, and error reporting.

## Interface
- DEPTH, 64: entry slots; power of two, ≥2
- STACK_DEPTH, 16: address-stack levels; power of two, ≥2
- ADDR_W, 64: address/offset width
- FID_W, 8: field_id width
- PAYLOAD_W, 64: opaque remaining entry bits (type, label, size), passed through untouched
- RESET_BASE, 'h100: stack[0] after reset
- clk  in  1  clock; reset  in  1  synchronous, active-high
- in_valid  in  1  producer offers an entry; in_ready  out  1  slot available
- in_field_id  in  FID_W; in_nested  in  1; in_offset  in  ADDR_W; in_payload  in  PAYLOAD_W
- out_valid  out  1  head entry present; out_ready  in  1  serializer consumes head
- out_field_id  out  FID_W; out_nested  out  1; out_offset  out  ADDR_W; out_payload  out  PAYLOAD_W
- root_addr  in  ADDR_W; root_addr_valid  in  1  load new top-level object base
- flush  in  1  discard all entries, return to nest level 0
- err_clear  in  1  clear sticky error flags
- base_addr  out  ADDR_W  current object base (stack[sp])
- nest_level  out  $clog2(STACK_DEPTH)  stack pointer sp
- occupancy  out  $clog2(DEPTH)+1  stored entry count
- err_overflow  out  1  sticky; err_underflow  out  1  sticky

## Operation
- Storage: ring of DEPTH slots; wr_ptr, rd_ptr, count registers. Pointers wrap modulo DEPTH.
- in_ready = (count != DEPTH), from registered count only. Push when in_valid & in_ready: slot[wr_ptr] written, wr_ptr+1.
- out_valid = (count != 0); out_* = slot[rd_ptr] (first-word fall-through). Pop when out_valid & out_ready: rd_ptr+1.
- Push and pop in the same cycle: count unchanged, both pointers advance. When full, in_ready=0, so no push occurs even with a concurrent pop.
- Address stack, evaluated only on a pop, using the popped entry:
  - field_id == 0 (end-of-object marker; in_nested ignored): if sp>0 then sp-1, else err_underflow<=1 with no change.
  - nested==1 and field_id != 0: if sp < STACK_DEPTH-1 then stack[sp+1] = stack[sp] + offset (mod 2^ADDR_W), sp+1; else err_overflow<=1 with no change.
  - Otherwise: stack unchanged.
- root_addr_valid: stack[0] <= root_addr, sp <= 0. Overrides any stack action of a concurrent pop; the entry is still popped.
- flush: count, wr_ptr, rd_ptr, sp <= 0. stack[0] and the error flags are kept. A concurrent push or pop is discarded. root_addr_valid in the same cycle still loads stack[0].
- err_clear: both flags <= 0. A same-cycle error event wins, so the flag ends at 1.
- Priority: reset > flush > root_addr_valid > normal push/pop/stack update.

## Timing
- Reset values: in_ready=1, out_valid=0, out_* = 0, occupancy=0, nest_level=0, base_addr=RESET_BASE, err_*=0. Storage contents are don't-care; out_* reads as 0 while empty.
- Push at edge N: out_valid=1 and occupancy updated after edge N (visible in cycle N+1); no bypass while empty.
- Pop at edge N: next head on out_* and new base_addr/nest_level are visible in cycle N+1.
- root_addr load, flush and error flags all take effect at the next edge.
- base_addr and nest_level are registers or muxes of registers; no combinational path from inputs to them.
- in_ready and out_valid do not depend combinationally on in_valid or out_ready.

## Test plan
- Reset, then idle: base_addr=0x100, occupancy=0, in_ready=1, out_valid=0, nest_level=0, both error flags 0.
- Push 64 entries (field_id 1..64) with out_ready=0: in_ready=0 after the 64th push. A 65th offer is held off with occupancy=64. Then drain with out_ready=1: field_ids come out 1..64 in order, and wrap-around is exercised by a second fill.
- root_addr=0x1000, then pop in order: nested off 0x20 -> base 0x1020, level 1; nested off 0x8 -> 0x1028, level 2; fid 0 -> 0x1020; fid 0 -> 0x1000; fid 0 -> err_underflow=1, base 0x1000, level 0.
- 15 nested pops each with offset 1 -> level 15, base 0x100F. A 16th nested pop -> err_overflow=1, level stays 15. err_clear -> flag 0.
- Simultaneous push and pop at occupancy 10 over 20 cycles: occupancy stays 10 and order is preserved. flush mid-stream -> occupancy 0, out_valid 0, level 0, base_addr = stack[0].
- Pop of a nested entry in the same cycle as root_addr_valid=0x2000: base 0x2000, level 0, and the entry is consumed (occupancy −1).
